// File: rtl/rfifo_pkg.sv
// Shared sizing helpers for the handshake FIFO family (rfifo and its variants).
package rfifo_pkg;

  // Occupancy counter width: must hold values 0..slots inclusive.
  function automatic int unsigned cnt_width(input int unsigned slots);
    return $clog2(slots + 32'd1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned slots);
    return (slots > 32'd1) ? $clog2(slots) : 32'd1;
  endfunction

endpackage

// File: rtl/rfifo_mem.sv
// Storage array for rfifo: one synchronous write port, asynchronous read at the head pointer.
module rfifo_mem
  import rfifo_pkg::*;
#(
  parameter int unsigned SLOTS      = 32'd2,
  parameter int unsigned DATA_WIDTH = 32'd32,
  localparam int unsigned PTR_W     = ptr_width(SLOTS)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_ptr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [SLOTS];

  // Payload storage is intentionally left unreset; pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr];

endmodule

// File: rtl/rfifo.sv
// Elastic FIFO with transparent forward path (bypass when empty) and ins_ready taken from a flop.
// Optional occupancy port enabled by defining RFIFO_COUNT_EN.
module rfifo
  import rfifo_pkg::*;
#(
  parameter int unsigned SLOTS      = 32'd2,
  parameter int unsigned DATA_WIDTH = 32'd32,
  localparam int unsigned CNT_W     = cnt_width(SLOTS),
  localparam int unsigned PTR_W     = ptr_width(SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
`ifdef RFIFO_COUNT_EN
  ,
  output logic [CNT_W-1:0]      count
`endif
);

  localparam logic [CNT_W-1:0] SLOTS_C  = CNT_W'(SLOTS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SLOTS - 32'd1);

  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  ready_r;
  logic                  empty_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Pointer increment that wraps at SLOTS-1, so non-power-of-2 depths work without masking.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1'b1);
    end
  endfunction

  assign empty_s  = (cnt_r == {CNT_W{1'b0}});
  assign accept_s = ins_valid & ready_r;
  assign pop_s    = ~empty_s & outs_ready;
  // An empty FIFO with a ready consumer hands the token straight through without storing it.
  assign push_s   = accept_s & ~(empty_s & outs_ready);

  // Next occupancy from the push/pop pair; simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1'b1);
      2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1'b1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Control state; ready is recomputed from next occupancy so no path exists from outs_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        tail_r <= wrap_inc(tail_r);
      end
      if (pop_s) begin
        head_r <= wrap_inc(head_r);
      end
      cnt_r   <= cnt_nxt_s;
      ready_r <= (cnt_nxt_s < SLOTS_C);
    end
  end

  rfifo_mem #(
    .SLOTS      (SLOTS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_ptr  (tail_r),
    .wr_data (ins),
    .rd_ptr  (head_r),
    .rd_data (rd_data_s)
  );

  assign ins_ready  = ready_r;
  assign outs_valid = ins_valid | ~empty_s;
  assign outs       = empty_s ? ins : rd_data_s;

`ifdef RFIFO_COUNT_EN
  assign count = cnt_r;
`endif

endmodule
